// File: rtl/imem_loader.sv
// imem_loader: packs UART bytes MSB-first into instruction words and writes them to consecutive IMEM addresses.
// Ends on a HALT opcode (done), an inter-byte timeout or an address overflow (error).
module imem_loader #(
    parameter int                   NB_DATA        = 32,
    parameter int                   NB_ADDR        = 8,
    parameter int                   NB_OPCODE      = 6,
    parameter logic [NB_OPCODE-1:0] HALT_OPCODE    = 6'b111111,
    parameter int                   TIMEOUT_CYCLES = 100000
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [7:0]         i_rx_data,
    input  logic               i_rx_done,
    output logic               o_im_write_enable,
    output logic [NB_DATA-1:0] o_im_data,
    output logic [NB_ADDR-1:0] o_im_addr,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_error,
    output logic [NB_ADDR:0]   o_word_count
);
    localparam int NB_TO = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, RECV, WRITE, DONE, ERROR} state_t;

    state_t             state, state_next;
    logic [1:0]         byte_cnt;
    logic [NB_DATA-9:0] shift;
    logic [NB_TO-1:0]   to_cnt;
    logic [NB_DATA-1:0] word;
    logic               halt, full, timeout;

    assign word    = {shift, i_rx_data};
    assign halt    = o_im_data[NB_DATA-1 -: NB_OPCODE] == HALT_OPCODE;
    assign full    = o_im_addr == '1;
    assign timeout = to_cnt == NB_TO'(TIMEOUT_CYCLES - 1);

    assign o_im_write_enable = state == WRITE;
    assign o_busy            = state == RECV || state == WRITE;
    assign o_done            = state == DONE;
    assign o_error           = state == ERROR;

    always_ff @(posedge i_clock or posedge i_reset)
        if (i_reset) state <= IDLE;
        else         state <= state_next;

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE, ERROR: state_next = i_start ? RECV : state;
            RECV: begin
                if (i_rx_done && byte_cnt == 2'd3) state_next = WRITE;
                else if (!i_rx_done && timeout)    state_next = ERROR;
            end
            WRITE:   state_next = halt ? DONE : full ? ERROR : RECV;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            byte_cnt     <= '0;
            shift        <= '0;
            to_cnt       <= '0;
            o_im_data    <= '0;
            o_im_addr    <= '0;
            o_word_count <= '0;
        end else begin
            case (state)
                IDLE, DONE, ERROR: if (i_start) begin
                    byte_cnt     <= '0;
                    to_cnt       <= '0;
                    o_im_addr    <= '0;
                    o_word_count <= '0;
                end
                RECV: if (i_rx_done) begin
                    shift    <= word[NB_DATA-9:0];
                    byte_cnt <= byte_cnt + 2'd1;
                    to_cnt   <= '0;
                    if (byte_cnt == 2'd3) o_im_data <= word;
                end else begin
                    to_cnt <= to_cnt + NB_TO'(1);
                end
                WRITE: begin
                    o_word_count <= o_word_count + (NB_ADDR+1)'(1);
                    to_cnt       <= '0;
                    // a byte arriving during the write strobe starts the next word
                    if (state_next == RECV) begin
                        o_im_addr <= o_im_addr + NB_ADDR'(1);
                        if (i_rx_done) begin
                            shift    <= word[NB_DATA-9:0];
                            byte_cnt <= 2'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed vectors plus hand sequences for timeout, overflow, back-to-back and reset.
module tb_imem_loader;
    logic        clk = 0, rst = 1;
    logic        i_start = 0, i_rx_done = 0;
    logic [7:0]  i_rx_data = 0;
    logic        o_im_write_enable, o_busy, o_done, o_error;
    logic [31:0] o_im_data;
    logic [1:0]  o_im_addr;
    logic [2:0]  o_word_count;

    int total = 0, bad = 0;
    logic [1:0]  wa[$];
    logic [31:0] wd[$];

    imem_loader #(.NB_ADDR(2), .TIMEOUT_CYCLES(50)) dut (
        .i_clock(clk), .i_reset(rst), .i_start(i_start), .i_rx_data(i_rx_data),
        .i_rx_done(i_rx_done), .o_im_write_enable(o_im_write_enable), .o_im_data(o_im_data),
        .o_im_addr(o_im_addr), .o_busy(o_busy), .o_done(o_done), .o_error(o_error),
        .o_word_count(o_word_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (o_im_write_enable) begin
            wa.push_back(o_im_addr);
            wd.push_back(o_im_data);
        end

    typedef struct {
        logic start, rxv; logic [7:0] rxd;
        logic we; logic [1:0] addr; logic [31:0] data;
        logic busy, done, err; logic [2:0] cnt;
    } vec_t;

    function automatic logic [40:0] outs();
        return {o_im_write_enable, o_im_addr, o_im_data, o_busy, o_done, o_error, o_word_count};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic s, input logic v, input logic [7:0] d);
        i_start = s; i_rx_done = v; i_rx_data = d;
        @(posedge clk); #1;
        i_start = 0; i_rx_done = 0;
    endtask

    initial begin
        vec_t tv[$];
        logic [31:0] words[4];
        logic [31:0] w;
        logic [1:0]  exp_a[$];
        logic [31:0] exp_d[$];
        int nwr;
        // start rxv rxd | we addr data busy done err cnt
        tv.push_back('{0, 1, 8'hAB, 0, 0, 32'h0,        0, 0, 0, 0}); // byte in IDLE ignored
        tv.push_back('{1, 0, 8'h00, 0, 0, 32'h0,        1, 0, 0, 0});
        tv.push_back('{0, 1, 8'h20, 0, 0, 32'h0,        1, 0, 0, 0});
        tv.push_back('{0, 1, 8'h01, 0, 0, 32'h0,        1, 0, 0, 0});
        tv.push_back('{1, 0, 8'h00, 0, 0, 32'h0,        1, 0, 0, 0}); // start while busy ignored
        tv.push_back('{0, 1, 8'h00, 0, 0, 32'h0,        1, 0, 0, 0});
        tv.push_back('{0, 1, 8'h05, 1, 0, 32'h20010005, 1, 0, 0, 0});
        tv.push_back('{0, 1, 8'hFC, 0, 1, 32'h20010005, 1, 0, 0, 1}); // byte in WRITE kept
        tv.push_back('{0, 1, 8'h00, 0, 1, 32'h20010005, 1, 0, 0, 1});
        tv.push_back('{0, 1, 8'h00, 0, 1, 32'h20010005, 1, 0, 0, 1});
        tv.push_back('{0, 1, 8'h00, 1, 1, 32'hFC000000, 1, 0, 0, 1});
        tv.push_back('{0, 0, 8'h00, 0, 1, 32'hFC000000, 0, 1, 0, 2});
        tv.push_back('{0, 1, 8'h55, 0, 1, 32'hFC000000, 0, 1, 0, 2}); // byte after DONE ignored
        tv.push_back('{1, 0, 8'h00, 0, 0, 32'hFC000000, 1, 0, 0, 0}); // restart clears done
        exp_a = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0};
        exp_d = '{32'h20010005, 32'hFC000000, 32'h01020304, 32'hAA223344,
                  32'hAA000001, 32'h0BADF00D, 32'h01020304, 32'hFC000000};

        repeat (2) @(posedge clk);
        #1 chk("reset_outputs", 64'(outs()), 64'h0);
        rst = 0;
        foreach (tv[i]) begin
            step(tv[i].start, tv[i].rxv, tv[i].rxd);
            chk($sformatf("vec%0d", i), 64'(outs()),
                64'({tv[i].we, tv[i].addr, tv[i].data, tv[i].busy, tv[i].done, tv[i].err, tv[i].cnt}));
        end

        // timeout: error exactly 50 idle cycles after the second byte
        step(0, 1, 8'h12);
        step(0, 1, 8'h34);
        nwr = wa.size();
        repeat (49) step(0, 0, 0);
        chk("timeout_not_yet", 64'(o_error), 64'd0);
        step(0, 0, 0);
        chk("timeout_error", 64'({o_error, o_busy, o_word_count}), 64'({1'b1, 1'b0, 3'd0}));
        chk("timeout_no_write", 64'(wa.size()), 64'(nwr));

        // overflow with back-to-back first bytes
        words = '{32'h01020304, 32'hAA223344, 32'hAA000001, 32'h0BADF00D};
        step(1, 0, 0);
        for (int k = 0; k < 4; k++) begin
            w = words[k];
            for (int b = (k == 0) ? 0 : 1; b < 4; b++) step(0, 1, w[31-8*b -: 8]);
            chk($sformatf("ovf_write%0d", k), 64'({o_im_write_enable, o_im_addr, o_im_data}),
                64'({1'b1, 2'(k), w}));
            if (k < 3) begin
                w = words[k+1];
                step(0, 1, w[31:24]);
            end else step(0, 1, 8'hEE);
        end
        chk("ovf_error", 64'({o_error, o_done, o_busy, o_word_count}), 64'({3'b100, 3'd4}));
        nwr = wa.size();
        for (int b = 0; b < 4; b++) step(0, 1, 8'h10 + 8'(b));
        chk("ovf_ignored", 64'({o_error, o_word_count, 8'(wa.size())}), 64'({1'b1, 3'd4, 8'(nwr)}));

        // reset in the middle of the second word
        step(1, 0, 0);
        for (int b = 0; b < 4; b++) step(0, 1, 8'(b + 1));
        step(0, 1, 8'h77);
        step(0, 1, 8'h88);
        rst = 1;
        #1 chk("midreset_outputs", 64'(outs()), 64'h0);
        @(posedge clk); #1 rst = 0;
        step(1, 0, 0);
        step(0, 1, 8'hFC);
        repeat (3) step(0, 1, 8'h00);
        chk("midreset_write", 64'({o_im_write_enable, o_im_addr, o_im_data}), 64'({1'b1, 2'd0, 32'hFC000000}));
        step(0, 0, 0);
        chk("midreset_done", 64'({o_done, o_error, o_busy, o_word_count}), 64'({3'b100, 3'd1}));

        @(negedge clk);
        chk("write_count", 64'(wa.size()), 64'(exp_a.size()));
        for (int k = 0; k < wa.size() && k < exp_a.size(); k++)
            chk($sformatf("write_log%0d", k), 64'({wa[k], wd[k]}), 64'({exp_a[k], exp_d[k]}));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
